// File: rtl/rice_bus_pkg.sv
// rice_bus_pkg
// Shared types and defaults for the rice bus arbiter slice.
// Contents:
//   RICE_BUS_* localparams   default geometry used by the arbiter parameters
//   rice_bus_master_id       requester index, $clog2(masters) bits (minimum 1)
//   rice_bus_access          one request: address, write flag, strobes, write data
//   nextMaster()             round-robin successor of a master index
package rice_bus_pkg;

  localparam int RICE_BUS_ADDRESS_WIDTH   = 32;
  localparam int RICE_BUS_DATA_WIDTH      = 32;
  localparam int RICE_BUS_STROBE_WIDTH    = RICE_BUS_DATA_WIDTH / 8;
  localparam int RICE_BUS_MASTERS         = 2;
  localparam int RICE_BUS_MAX_OUTSTANDING = 2;
  localparam int RICE_BUS_ID_WIDTH        = (RICE_BUS_MASTERS > 1) ? $clog2(RICE_BUS_MASTERS) : 1;

  typedef logic [RICE_BUS_ID_WIDTH-1:0] rice_bus_master_id;

  typedef struct packed {
    logic [RICE_BUS_ADDRESS_WIDTH-1:0] address;
    logic                              write;
    logic [RICE_BUS_STROBE_WIDTH-1:0]  strobe;
    logic [RICE_BUS_DATA_WIDTH-1:0]    write_data;
  } rice_bus_access;

  // The successor wraps explicitly so non-power-of-two master counts work.
  function automatic rice_bus_master_id nextMaster(input rice_bus_master_id id);
    if (int'(id) == RICE_BUS_MASTERS - 1) begin
      return '0;
    end
    return id + rice_bus_master_id'(1);
  endfunction

endpackage

// File: rtl/rice_bus_arbiter_fifo.sv
// rice_bus_arbiter_fifo
// Remembers which master issued each accepted-but-unanswered transaction, in order.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_push_id     record a newly accepted transaction's master
//   i_pop                 retire the oldest entry (ignored while empty)
//   o_head_id             master of the oldest outstanding transaction
//   o_empty, o_full       occupancy flags
module rice_bus_arbiter_fifo
  import rice_bus_pkg::*;
#(
  parameter int DEPTH = RICE_BUS_MAX_OUTSTANDING
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  rice_bus_master_id i_push_id,
  input  logic              i_pop,
  output rice_bus_master_id o_head_id,
  output logic              o_empty,
  output logic              o_full
);

  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [PTR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  rice_bus_master_id      mem_q [DEPTH];
  logic                   doPush, doPop;

  // Pointers wrap modulo DEPTH rather than modulo 2**PTR_WIDTH.
  function automatic logic [PTR_WIDTH-1:0] wrapInc(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_WIDTH'(1);
  endfunction

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == COUNT_WIDTH'(DEPTH));
  assign o_head_id = mem_q[head_q];

  // A pop on an empty FIFO is a stray response and must leave no trace.
  always_comb begin
    doPush  = i_push && !o_full;
    doPop   = i_pop && !o_empty;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (doPush) begin
      tail_d = wrapInc(tail_q);
    end
    if (doPop) begin
      head_d = wrapInc(head_q);
    end
    if (doPush && !doPop) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (doPush) begin
        mem_q[tail_q] <= i_push_id;
      end
    end
  end

endmodule

// File: rtl/rice_bus_arbiter.sv
// rice_bus_arbiter
// Shares one memory bus between the fetch (master 0) and load/store (master 1)
// requesters, holds a grant until the slave accepts it and routes in-order
// responses back to the issuing master.
// Configuration macro: RICE_BUS_ARBITER_ROUND_ROBIN_EN
//   defined     round-robin, search starts at a pointer that moves past each winner
//   undefined   fixed priority, highest master index wins
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_m_valid/o_m_ready                  per-master request handshake
//   i_m_address/write/strobe/write_data  per-master request fields, flattened
//   o_m_response                         per-master response strobe
//   o_m_read_data, o_m_error             shared response payload
//   o_s_valid/i_s_ready                  slave request handshake
//   o_s_address/write/strobe/write_data  request fields of the current winner
//   i_s_response/read_data/error         in-order slave response
module rice_bus_arbiter
  import rice_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = RICE_BUS_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = RICE_BUS_DATA_WIDTH,
  parameter int MASTERS         = RICE_BUS_MASTERS,
  parameter int MAX_OUTSTANDING = RICE_BUS_MAX_OUTSTANDING
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [MASTERS-1:0]                i_m_valid,
  output logic [MASTERS-1:0]                o_m_ready,
  input  logic [MASTERS*ADDRESS_WIDTH-1:0]  i_m_address,
  input  logic [MASTERS-1:0]                i_m_write,
  input  logic [MASTERS*DATA_WIDTH/8-1:0]   i_m_strobe,
  input  logic [MASTERS*DATA_WIDTH-1:0]     i_m_write_data,
  output logic [MASTERS-1:0]                o_m_response,
  output logic [DATA_WIDTH-1:0]             o_m_read_data,
  output logic                              o_m_error,
  output logic                              o_s_valid,
  input  logic                              i_s_ready,
  output logic [ADDRESS_WIDTH-1:0]          o_s_address,
  output logic                              o_s_write,
  output logic [DATA_WIDTH/8-1:0]           o_s_strobe,
  output logic [DATA_WIDTH-1:0]             o_s_write_data,
  input  logic                              i_s_response,
  input  logic [DATA_WIDTH-1:0]             i_s_read_data,
  input  logic                              i_s_error
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  logic              lock_q, lock_d;
  rice_bus_master_id grant_q, grant_d;
`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
  rice_bus_master_id rr_q, rr_d;
`endif
  rice_bus_master_id winner, headId;
  rice_bus_access    access;
  logic              fifoFull, fifoEmpty, sValid, transfer, pop;

  // While locked the registered grant wins; otherwise the priority rule picks.
  always_comb begin
    winner = '0;
    if (lock_q) begin
      winner = grant_q;
    end else begin
`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
      // Scanning offsets downwards lets the smallest offset from the pointer win.
      for (int off = MASTERS - 1; off >= 0; off--) begin
        if (i_m_valid[(int'(rr_q) + off) % MASTERS]) begin
          winner = rice_bus_master_id'((int'(rr_q) + off) % MASTERS);
        end
      end
`else
      for (int i = 0; i < MASTERS; i++) begin
        if (i_m_valid[i]) begin
          winner = rice_bus_master_id'(i);
        end
      end
`endif
    end
  end

  // A full response FIFO blocks requests even if a response retires this cycle,
  // keeping the push path independent of the response input.
  assign sValid   = !i_rst && !fifoFull && (lock_q || (|i_m_valid));
  assign transfer = sValid && i_s_ready;
  assign pop      = !i_rst && i_s_response && !fifoEmpty;

  always_comb begin
    access.address    = i_m_address[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    access.write      = i_m_write[winner];
    access.strobe     = i_m_strobe[int'(winner)*STROBE_WIDTH +: STROBE_WIDTH];
    access.write_data = i_m_write_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Outputs are forced to zero whenever no request or response is live.
  always_comb begin
    o_s_valid      = sValid;
    o_s_address    = sValid ? access.address : '0;
    o_s_write      = sValid && access.write;
    o_s_strobe     = sValid ? access.strobe : '0;
    o_s_write_data = sValid ? access.write_data : '0;
    o_m_ready      = '0;
    if (transfer) begin
      o_m_ready[winner] = 1'b1;
    end
    o_m_response = '0;
    if (pop) begin
      o_m_response[headId] = 1'b1;
    end
    o_m_read_data = pop ? i_s_read_data : '0;
    o_m_error     = pop && i_s_error;
  end

  // A request left waiting freezes the grant until the slave takes it.
  always_comb begin
    lock_d  = lock_q;
    grant_d = grant_q;
    if (transfer) begin
      lock_d = 1'b0;
    end else if (sValid) begin
      lock_d  = 1'b1;
      grant_d = winner;
    end
  end

`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    rr_d = rr_q;
    if (transfer) begin
      rr_d = nextMaster(winner);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      lock_q  <= lock_d;
      grant_q <= grant_d;
    end
  end

  rice_bus_arbiter_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (transfer),
    .i_push_id(winner),
    .i_pop    (pop),
    .o_head_id(headId),
    .o_empty  (fifoEmpty),
    .o_full   (fifoFull)
  );

endmodule
